// File: rtl/sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbox_pkg
// Description : Shared types, reference S-box tables and table lookup helper
//               for the sequenced dual-rail S-box.
// Revision    : 1.0 - initial release
// ============================================================================
package sbox_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    EVAL      = 2'd2,
    DONE      = 2'd3
  } sbox_state_e;

  localparam int SBOX_MAX_OUT_W = 32;
  localparam int SBOX_MAX_TBL_W = 4096;

  // Entry i lives at [i*4 +: 4]; entry 0 sits in the least significant nibble.
  localparam logic [63:0] LUCIFER_S0 = 64'h8549_1362_0BDE_A7FC;
  localparam logic [63:0] LUCIFER_S1 = 64'h58F6_A1DC_40B3_9E27;

  function automatic logic [SBOX_MAX_OUT_W-1:0] sbox_entry(
    input logic [SBOX_MAX_TBL_W-1:0] table_bits,
    input int unsigned               idx,
    input int unsigned               out_w
  );
    logic [SBOX_MAX_OUT_W-1:0] r;
    logic [11:0]               pos;
    r = '0;
    for (int unsigned b = 0; b < SBOX_MAX_OUT_W; b++) begin
      pos = 12'(idx * out_w + b);
      if (b < out_w) r[b[4:0]] = table_bits[pos];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_rail_encode.sv
`default_nettype none
// ============================================================================
// Module      : sbox_rail_encode
// Description : Combinational dual-rail encoder; value on u, its complement on
//               c, both rails low (spacer) when not enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_rail_encode
  import sbox_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic [OUT_W-1:0] value,
  input  logic             en,
  output logic [OUT_W-1:0] u,
  output logic [OUT_W-1:0] c
);

  assign u = en ? value  : '0;
  assign c = en ? ~value : '0;

endmodule
`default_nettype wire

// File: rtl/sbox_dualrail_seq.sv
`default_nettype none
// ============================================================================
// Module      : sbox_dualrail_seq
// Description : Clocked dual-rail S-box with explicit precharge/evaluate phases
//               and valid/ready on both sides. Define SBOX_INVERSE_EN to add
//               the inverse-lookup scan (in_inv / inv_miss ports).
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_dualrail_seq
  import sbox_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 4,
  parameter     TABLE    = LUCIFER_S0,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
`ifdef SBOX_INVERSE_EN
  input  logic             in_inv,
  output logic             inv_miss,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_u,
  output logic [OUT_W-1:0] out_c,
  output logic             pre,
  output logic             busy
);

  localparam int DEPTH     = 2 ** IN_W;
  localparam int CNT_MAX_A = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > DEPTH) ? CNT_MAX_A : DEPTH;
  localparam int CNT_W     = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]          PRE_LAST  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0]          EVAL_LAST = CNT_W'(EVAL_CYC - 1);
  localparam logic [SBOX_MAX_TBL_W-1:0] TABLE_EXT = SBOX_MAX_TBL_W'(TABLE);
`ifdef SBOX_INVERSE_EN
  localparam logic [CNT_W-1:0]          SCAN_LAST = CNT_W'(DEPTH - 1);
`endif

  generate
    if (PRE_CYC < 1) begin : g_bad_pre
      $error("sbox_dualrail_seq: PRE_CYC must be >= 1");
    end
    if (EVAL_CYC < 1) begin : g_bad_eval
      $error("sbox_dualrail_seq: EVAL_CYC must be >= 1");
    end
    if ($bits(TABLE) != OUT_W * DEPTH) begin : g_bad_table
      $error("sbox_dualrail_seq: TABLE width must be OUT_W*2**IN_W");
    end
    if ($bits(TABLE) > SBOX_MAX_TBL_W || OUT_W > SBOX_MAX_OUT_W) begin : g_too_big
      $error("sbox_dualrail_seq: TABLE or OUT_W exceeds supported size");
    end
`ifdef SBOX_INVERSE_EN
    if (IN_W != OUT_W) begin : g_bad_inv
      $error("sbox_dualrail_seq: inverse lookup requires IN_W == OUT_W");
    end
`endif
  endgenerate

  sbox_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0] out_u_q, out_u_d;
  logic [OUT_W-1:0] out_c_q, out_c_d;
  logic             out_valid_q, out_valid_d;
`ifdef SBOX_INVERSE_EN
  logic             inv_q, inv_d;
  logic             inv_miss_q, inv_miss_d;
`endif

  logic [IN_W-1:0]  entry_sel;
  logic [OUT_W-1:0] entry;
  logic             load_en;
  logic [OUT_W-1:0] load_val;
  logic             hold;
  logic [OUT_W-1:0] enc_u, enc_c;

`ifdef SBOX_INVERSE_EN
  // In inverse mode the counter doubles as the table scan pointer.
  assign entry_sel = inv_q ? cnt_q[IN_W-1:0] : idx_q;
`else
  assign entry_sel = idx_q;
`endif
  assign entry = OUT_W'(sbox_entry(TABLE_EXT, 32'(entry_sel), OUT_W));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    load_en     = 1'b0;
    load_val    = entry;
`ifdef SBOX_INVERSE_EN
    inv_d       = inv_q;
    inv_miss_d  = inv_miss_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          idx_d   = in_data;
          cnt_d   = '0;
          state_d = PRECHARGE;
`ifdef SBOX_INVERSE_EN
          inv_d   = in_inv;
`endif
        end
      end
      PRECHARGE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EVAL: begin
`ifdef SBOX_INVERSE_EN
        if (inv_q) begin
          if (entry == idx_q[OUT_W-1:0]) begin
            load_en    = 1'b1;
            load_val   = OUT_W'(cnt_q[IN_W-1:0]);
            inv_miss_d = 1'b0;
          end else if (cnt_q == SCAN_LAST) begin
            load_en    = 1'b1;
            load_val   = '0;
            inv_miss_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else
`endif
        if (cnt_q == EVAL_LAST) begin
          load_en = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (load_en) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef SBOX_INVERSE_EN
          inv_miss_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rails take the encoder output except while a result is being held.
  assign hold = (state_q == DONE) && !out_ready;

  sbox_rail_encode #(
    .OUT_W (OUT_W)
  ) u_rail_encode (
    .value (load_val),
    .en    (load_en),
    .u     (enc_u),
    .c     (enc_c)
  );

  always_comb begin
    out_u_d = hold ? out_u_q : enc_u;
    out_c_d = hold ? out_c_q : enc_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_u_q     <= '0;
      out_c_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef SBOX_INVERSE_EN
      inv_q       <= 1'b0;
      inv_miss_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_u_q     <= out_u_d;
      out_c_q     <= out_c_d;
      out_valid_q <= out_valid_d;
`ifdef SBOX_INVERSE_EN
      inv_q       <= inv_d;
      inv_miss_q  <= inv_miss_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign pre       = (state_q == PRECHARGE);
  assign out_valid = out_valid_q;
  assign out_u     = out_u_q;
  assign out_c     = out_c_q;
`ifdef SBOX_INVERSE_EN
  assign inv_miss  = inv_miss_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sbox_dualrail_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbox_dualrail_seq
// Description : Self-checking bench; two DUT configurations compared each
//               cycle against a timestamp-based transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbox_dualrail_seq;
  import sbox_pkg::*;

  localparam int NI = 2;
  // LUCIFER_S0 with entry 15 changed from 8 to 12: value 8 never appears.
  localparam logic [63:0] TBL_B = 64'hC549_1362_0BDE_A7FC;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [3:0] in_data   [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic [3:0] out_u     [NI];
  logic [3:0] out_c     [NI];
  logic       pre       [NI];
  logic       busy      [NI];
`ifdef SBOX_INVERSE_EN
  logic       in_inv    [NI];
  logic       inv_miss  [NI];
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int ref_tbl [NI][16] = '{'{12,15,7,10,14,13,11,0,2,6,3,1,9,4,5,8},
                           '{12,15,7,10,14,13,11,0,2,6,3,1,9,4,5,12}};
  int pre_n [NI] = '{1, 3};

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h at t=%0t", name, inst, act, exp, $time);
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int          PRE = (gi == 0) ? 1 : 3;
    localparam int          EVL = (gi == 0) ? 1 : 2;
    localparam logic [63:0] TBL = (gi == 0) ? LUCIFER_S0 : TBL_B;

    logic inv_now;
`ifdef SBOX_INVERSE_EN
    assign inv_now = in_inv[gi];
`else
    assign inv_now = 1'b0;
`endif

    sbox_dualrail_seq #(
      .IN_W(4), .OUT_W(4), .TABLE(TBL), .PRE_CYC(PRE), .EVAL_CYC(EVL)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]), .in_data(in_data[gi]),
`ifdef SBOX_INVERSE_EN
      .in_inv(in_inv[gi]), .inv_miss(inv_miss[gi]),
`endif
      .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
      .out_u(out_u[gi]), .out_c(out_c[gi]), .pre(pre[gi]), .busy(busy[gi])
    );

    // Transaction model: age counts edges since the accepting handshake.
    bit m_busy, m_done, m_miss;
    int m_age, m_len, m_exp;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy = 0; m_done = 0; m_miss = 0; m_age = 0;
      end else if (!m_busy) begin
        if (in_valid[gi]) begin
          m_busy = 1; m_done = 0; m_age = 0; m_miss = 0;
          if (inv_now) begin
            m_exp = -1;
            for (int e = 0; e < 16; e++)
              if (m_exp < 0 && ref_tbl[gi][e] == int'(in_data[gi])) m_exp = e;
            if (m_exp < 0) begin m_exp = 0; m_len = 16; m_miss = 1; end
            else m_len = m_exp + 1;
          end else begin
            m_exp = ref_tbl[gi][in_data[gi]];
            m_len = EVL;
          end
        end
      end else if (m_done) begin
        if (out_ready[gi]) begin m_busy = 0; m_done = 0; m_miss = 0; end
      end else begin
        m_age++;
        if (m_age == PRE + m_len) m_done = 1;
      end
    end

    logic [3:0] e_u, e_c;
    always @(posedge clk) begin
      #1;
      if (!rst) begin
        e_u = m_done ? m_exp[3:0] : 4'h0;
        e_c = m_done ? ~m_exp[3:0] : 4'h0;
        chk("in_ready", gi, in_ready[gi], !m_busy);
        chk("busy", gi, busy[gi], m_busy);
        chk("pre", gi, pre[gi], m_busy && !m_done && (m_age < PRE));
        chk("out_valid", gi, out_valid[gi], m_done);
        chk("out_u", gi, out_u[gi], e_u);
        chk("out_c", gi, out_c[gi], e_c);
        chk("rail_xor", gi, &(out_u[gi] ^ out_c[gi]), m_done);
        chk("rail_overlap", gi, |(out_u[gi] & out_c[gi]), 0);
`ifdef SBOX_INVERSE_EN
        chk("inv_miss", gi, inv_miss[gi], m_done && m_miss);
`endif
      end
    end
  end

  task automatic do_xfer(input int i, input logic [3:0] d, input bit inv, input int ev,
                         input logic [3:0] exp_u, input bit exp_miss);
    int lat, waited;
    logic [3:0] exp_c;
    lat   = pre_n[i] + ev + 1;
    exp_c = ~exp_u;
    @(negedge clk);
    in_valid[i] = 1'b1; in_data[i] = d; out_ready[i] = 1'b1;
`ifdef SBOX_INVERSE_EN
    in_inv[i] = inv;
`endif
    waited = 0;
    while (!in_ready[i] && waited < 50) begin @(negedge clk); waited++; end
    chk("x_accept_wait", i, waited < 50, 1);
    @(posedge clk); #1;
    for (int c = 1; c <= lat; c++) begin
      chk("x_pre", i, pre[i], c <= pre_n[i]);
      chk("x_valid", i, out_valid[i], c == lat);
      if (c == 1) in_valid[i] = 1'b0;
      if (c < lat) begin @(posedge clk); #1; end
    end
    chk("x_out_u", i, out_u[i], exp_u);
    chk("x_out_c", i, out_c[i], exp_c);
`ifdef SBOX_INVERSE_EN
    chk("x_inv_miss", i, inv_miss[i], exp_miss);
`else
    if (inv || exp_miss) chk("x_inv_unsupported", i, 1, 0);
`endif
    @(posedge clk); #1;
    chk("x_release_ready", i, in_ready[i], 1);
    chk("x_release_u", i, out_u[i], 0);
    chk("x_release_c", i, out_c[i], 0);
  endtask

  task automatic wait_valid(input int i);
    int waited;
    waited = 0;
    while (!out_valid[i] && waited < 30) begin @(posedge clk); #1; waited++; end
    chk("wait_valid", i, waited < 30, 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 0; in_data[i] = 0; out_ready[i] = 0;
`ifdef SBOX_INVERSE_EN
      in_inv[i] = 0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_u", i, out_u[i], 0);
      chk("rst_out_c", i, out_c[i], 0);
      chk("rst_valid", i, out_valid[i], 0);
      chk("rst_pre", i, pre[i], 0);
      chk("rst_busy", i, busy[i], 0);
      chk("rst_in_ready", i, in_ready[i], 1);
    end
    @(negedge clk); rst = 1'b0;

    do_xfer(0, 4'd0, 0, 1, 4'b1100, 0);
    do_xfer(0, 4'd7, 0, 1, 4'b0000, 0);
    do_xfer(1, 4'd0, 0, 2, 4'b1100, 0);
    do_xfer(1, 4'd15, 0, 2, 4'b1100, 0);
    for (int d = 0; d < 16; d++) do_xfer(0, 4'(d), 0, 1, 4'(ref_tbl[0][d]), 0);

    // Backpressure: result 5 -> 13 held for 10 cycles with in_data wandering.
    @(negedge clk);
    in_valid[0] = 1; in_data[0] = 4'd5; out_ready[0] = 0;
    @(posedge clk); #1;
    wait_valid(0);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_u", 0, out_u[0], 4'b1101);
      chk("bp_out_c", 0, out_c[0], 4'b0010);
      chk("bp_in_ready", 0, in_ready[0], 0);
      in_data[0] = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid[0] = 0; out_ready[0] = 1;
    @(posedge clk); #1;
    chk("bp_rel_u", 0, out_u[0], 0);
    chk("bp_rel_c", 0, out_c[0], 0);
    chk("bp_rel_ready", 0, in_ready[0], 1);
    chk("bp_rel_valid", 0, out_valid[0], 0);

    // Reset during PRECHARGE.
    @(negedge clk);
    in_valid[0] = 1; in_data[0] = 4'd9; out_ready[0] = 1;
    @(posedge clk); #1;
    in_valid[0] = 0;
    chk("rp_pre_before", 0, pre[0], 1);
    #2 rst = 1'b1; #1;
    chk("rp_out_u", 0, out_u[0], 0);
    chk("rp_valid", 0, out_valid[0], 0);
    chk("rp_busy", 0, busy[0], 0);
    chk("rp_pre", 0, pre[0], 0);
    chk("rp_ready", 0, in_ready[0], 1);
    @(negedge clk); rst = 1'b0;

    // Reset during DONE.
    @(negedge clk);
    in_valid[0] = 1; in_data[0] = 4'd9; out_ready[0] = 0;
    @(posedge clk); #1;
    in_valid[0] = 0;
    wait_valid(0);
    #2 rst = 1'b1; #1;
    chk("rd_out_u", 0, out_u[0], 0);
    chk("rd_out_c", 0, out_c[0], 0);
    chk("rd_valid", 0, out_valid[0], 0);
    chk("rd_ready", 0, in_ready[0], 1);
    @(negedge clk); rst = 1'b0; out_ready[0] = 1;
    do_xfer(0, 4'd3, 0, 1, 4'b1010, 0);

`ifdef SBOX_INVERSE_EN
    do_xfer(0, 4'd8, 1, 16, 4'b1111, 0);
    do_xfer(0, 4'd12, 1, 1, 4'b0000, 0);
    do_xfer(1, 4'd8, 1, 16, 4'b0000, 1);
    in_inv[0] = 0; in_inv[1] = 0;
`endif

    repeat (3000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NI; i++) begin
        in_valid[i]  = 1'($urandom_range(0, 1));
        in_data[i]   = 4'($urandom);
        out_ready[i] = ($urandom_range(0, 3) != 0);
`ifdef SBOX_INVERSE_EN
        in_inv[i]    = ($urandom_range(0, 3) == 0);
`endif
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin in_valid[i] = 0; out_ready[i] = 1; end
    repeat (5) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
